// File: rtl/active_sb_responder.sv
// Partner-side responder for the LTSM ACTIVE sideband handshake.
// Optional build macro ACTIVE_RSP_STRICT_EN: stray messages in WAIT_REQ/DONE raise an error instead of being dropped.

package SB_codex_pkg;
  typedef enum logic [3:0] {
    NOP        = 4'h0,
    ACTIVE_REQ = 4'h1,
    ACTIVE_RSP = 4'h2,
    LINK_MGMT  = 4'h3
  } SB_msg_t;
endpackage

module active_sb_responder
  import SB_codex_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 800000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic    clk_100MHz,
  input  logic    reset,
  input  logic    enable_i,
  input  SB_msg_t RX_msg_i,
  input  logic    RX_msg_valid_i,
  output logic    RX_msg_req_o,
  output SB_msg_t TX_msg_o,
  output logic    TX_msg_valid_o,
  input  logic    TX_msg_valid_ack_i,
  output logic    active_done_o,
  output logic    error_o,
  output logic    reset_state_timeout_counter_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_REQ = 3'd1,
    S_SEND_RSP = 3'd2,
    S_DONE     = 3'd3,
    S_ERROR    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             rx_req_q, rx_req_d;
  logic             tx_valid_q, tx_valid_d;
  SB_msg_t          tx_msg_q, tx_msg_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             rst_cnt_q, rst_cnt_d;

  logic rx_accept, req_in, stray, tx_acked, timed_out;

  // Next-state and timer; disable outranks everything, and a REQ accept outranks the timeout.
  always_comb begin
    rx_accept = rx_req_q && RX_msg_valid_i;
    req_in    = rx_accept && (RX_msg_i == ACTIVE_REQ);
    stray     = rx_accept && (RX_msg_i != ACTIVE_REQ);
    tx_acked  = tx_valid_q && TX_msg_valid_ack_i;
    timed_out = (timer_q >= TERMINAL);
    state_d   = state_q;
    timer_d   = timer_q;
    if (!enable_i) begin
      state_d = S_IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_WAIT_REQ;
          timer_d = '0;
        end
        S_WAIT_REQ: begin
          if (req_in) begin
            state_d = S_SEND_RSP;
            timer_d = timer_q + ONE;
`ifdef ACTIVE_RSP_STRICT_EN
          end else if (stray || timed_out) begin
`else
          end else if (timed_out) begin
`endif
            state_d = S_ERROR;
            timer_d = '0;
          end else begin
            timer_d = timer_q + ONE;
          end
        end
        S_SEND_RSP: begin
          if (timed_out) begin
            state_d = S_ERROR;
            timer_d = '0;
          end else if (tx_acked) begin
            state_d = S_DONE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + ONE;
          end
        end
        S_DONE: begin
          timer_d = '0;
          if (req_in) begin
            state_d = S_SEND_RSP;
`ifdef ACTIVE_RSP_STRICT_EN
          end else if (stray) begin
            state_d = S_ERROR;
`endif
          end else begin
            state_d = S_DONE;
          end
        end
        S_ERROR: begin
          timer_d = '0;
        end
        default: begin
          state_d = S_IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  // Moore output decode from the upcoming state so outputs register together with it.
  always_comb begin
    rx_req_d   = 1'b0;
    tx_valid_d = 1'b0;
    tx_msg_d   = NOP;
    done_d     = 1'b0;
    err_d      = 1'b0;
    rst_cnt_d  = 1'b1;
    case (state_d)
      S_WAIT_REQ: begin
        rx_req_d  = 1'b1;
        rst_cnt_d = 1'b0;
      end
      S_SEND_RSP: begin
        tx_valid_d = 1'b1;
        tx_msg_d   = ACTIVE_RSP;
        rst_cnt_d  = 1'b0;
      end
      S_DONE: begin
        rx_req_d = 1'b1;
        done_d   = 1'b1;
      end
      S_ERROR: begin
        err_d = 1'b1;
      end
      default: begin
        rst_cnt_d = 1'b1;
      end
    endcase
  end

  // State, timer and registered outputs.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      rx_req_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_msg_q   <= NOP;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rst_cnt_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      rx_req_q   <= rx_req_d;
      tx_valid_q <= tx_valid_d;
      tx_msg_q   <= tx_msg_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rst_cnt_q  <= rst_cnt_d;
    end
  end

  assign RX_msg_req_o                  = rx_req_q;
  assign TX_msg_valid_o                = tx_valid_q;
  assign TX_msg_o                      = tx_msg_q;
  assign active_done_o                 = done_q;
  assign error_o                       = err_q;
  assign reset_state_timeout_counter_o = rst_cnt_q;

endmodule

// File: tb/tb_active_sb_responder.sv
// Directed bench for active_sb_responder: a phase-flag model checked every cycle plus literal expectations.
`timescale 1ns/1ps
module tb_active_sb_responder;
  import SB_codex_pkg::*;

  localparam int TC = 20;
`ifdef ACTIVE_RSP_STRICT_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic    clk_100MHz = 1'b0;
  logic    reset      = 1'b1;
  logic    enable_i   = 1'b0;
  SB_msg_t rx_msg     = NOP;
  logic    rx_valid   = 1'b0;
  logic    ack        = 1'b0;
  logic    rx_req, tx_valid, done_o, err_o, rst_cnt;
  SB_msg_t tx_msg;

  int checks   = 0;
  int failures = 0;

  always #5 clk_100MHz = ~clk_100MHz;

  active_sb_responder #(.TIMEOUT_CYCLES(TC), .CNT_W(20)) dut (
    .clk_100MHz                    (clk_100MHz),
    .reset                         (reset),
    .enable_i                      (enable_i),
    .RX_msg_i                      (rx_msg),
    .RX_msg_valid_i                (rx_valid),
    .RX_msg_req_o                  (rx_req),
    .TX_msg_o                      (tx_msg),
    .TX_msg_valid_o                (tx_valid),
    .TX_msg_valid_ack_i            (ack),
    .active_done_o                 (done_o),
    .error_o                       (err_o),
    .reset_state_timeout_counter_o (rst_cnt)
  );

  // Model: which phase of the handshake we are in, and cycles spent waiting.
  typedef struct packed {
    bit waiting;
    bit pending;
    bit done;
    bit failed;
    int elapsed;
  } model_t;

  model_t m = '0;

  function automatic model_t step(model_t s, bit en, bit rv, SB_msg_t msg, bit ak);
    model_t n = s;
    bit taken = (s.waiting || s.done) && rv;
    bit is_req = taken && (msg == ACTIVE_REQ);
    if (!en) n = '0;
    else if (s.failed) n = s;
    else if (s.waiting) begin
      if (is_req) begin n.waiting = 0; n.pending = 1; n.elapsed = s.elapsed + 1; end
      else if ((STRICT && taken) || s.elapsed >= TC - 1) begin n = '0; n.failed = 1; end
      else n.elapsed = s.elapsed + 1;
    end else if (s.pending) begin
      if (s.elapsed >= TC - 1) begin n = '0; n.failed = 1; end
      else if (ak) begin n = '0; n.done = 1; end
      else n.elapsed = s.elapsed + 1;
    end else if (s.done) begin
      if (is_req) begin n = '0; n.pending = 1; end
      else if (STRICT && taken) begin n = '0; n.failed = 1; end
    end else begin
      n = '0; n.waiting = 1;
    end
    return n;
  endfunction

  always @(posedge clk_100MHz or posedge reset) begin
    if (reset) m <= '0;
    else       m <= step(m, enable_i, rx_valid, rx_msg, ack);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk_100MHz) begin
    chk("m_rx_req",   32'(rx_req),   32'(m.waiting | m.done));
    chk("m_tx_valid", 32'(tx_valid), 32'(m.pending));
    chk("m_tx_msg",   32'(tx_msg),   32'(m.pending ? ACTIVE_RSP : NOP));
    chk("m_done",     32'(done_o),   32'(m.done));
    chk("m_err",      32'(err_o),    32'(m.failed));
    chk("m_rst_cnt",  32'(rst_cnt),  32'(!(m.waiting | m.pending)));
  end

  task automatic tick();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic send(input SB_msg_t msg);
    rx_msg = msg; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0; rx_msg = NOP;
  endtask

  initial begin
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("rst_rx_req", 32'(rx_req), 32'(0));
    chk("rst_cnt", 32'(rst_cnt), 32'(1));
    chk("rst_tx_msg", 32'(tx_msg), 32'(NOP));
    chk("rst_err", 32'(err_o), 32'(0));

    // Basic handshake
    enable_i = 1'b1;
    tick();
    chk("wait_rx_req", 32'(rx_req), 32'(1));
    chk("wait_rst_cnt", 32'(rst_cnt), 32'(0));
    repeat (5) tick();
    send(ACTIVE_REQ);
    chk("rsp_valid", 32'(tx_valid), 32'(1));
    chk("rsp_msg", 32'(tx_msg), 32'(ACTIVE_RSP));
    chk("rsp_rx_req", 32'(rx_req), 32'(0));
    tick();
    chk("rsp_hold", 32'(tx_msg), 32'(ACTIVE_RSP));
    ack = 1'b1; tick(); ack = 1'b0;
    chk("done_set", 32'(done_o), 32'(1));
    chk("done_tx_off", 32'(tx_valid), 32'(0));
    chk("done_rst_cnt", 32'(rst_cnt), 32'(1));

    // Repeated request
    send(ACTIVE_REQ);
    chk("rep_done_drop", 32'(done_o), 32'(0));
    chk("rep_msg", 32'(tx_msg), 32'(ACTIVE_RSP));
    tick();
    ack = 1'b1; tick(); ack = 1'b0;
    chk("rep_done", 32'(done_o), 32'(1));

    // Stray message, plus an ack while nothing is offered
    enable_i = 1'b0; tick();
    chk("idle_done", 32'(done_o), 32'(0));
    enable_i = 1'b1; tick();
    ack = 1'b1; tick(); ack = 1'b0;
    chk("stray_ack_ignored", 32'(tx_valid), 32'(0));
    send(NOP);
    chk("stray_err", 32'(err_o), 32'(STRICT));
    chk("stray_rx_req", 32'(rx_req), 32'(!STRICT));
    send(ACTIVE_REQ);
    chk("stray_rsp", 32'(tx_valid), 32'(!STRICT));
    ack = 1'b1; tick(); ack = 1'b0;
    chk("stray_done", 32'(done_o), 32'(!STRICT));
    enable_i = 1'b0; tick();

    // Abort with a same-cycle ack
    enable_i = 1'b1; tick(); tick();
    send(ACTIVE_REQ);
    chk("abort_pre", 32'(tx_valid), 32'(1));
    enable_i = 1'b0; ack = 1'b1; tick(); ack = 1'b0;
    chk("abort_tx", 32'(tx_valid), 32'(0));
    chk("abort_done", 32'(done_o), 32'(0));
    chk("abort_msg", 32'(tx_msg), 32'(NOP));

    // Timeout: error appears at the TC-th edge after the enable-sampling edge
    enable_i = 1'b1;
    for (int k = 0; k <= TC; k++) begin
      tick();
      chk("timeout_edge", 32'(err_o), 32'(k == TC));
    end
    chk("timeout_rx_req", 32'(rx_req), 32'(0));
    chk("timeout_rst_cnt", 32'(rst_cnt), 32'(1));
    repeat (3) tick();
    chk("timeout_sticky", 32'(err_o), 32'(1));
    enable_i = 1'b0; tick();
    chk("timeout_clear", 32'(err_o), 32'(0));

    // Accept on the terminal count wins; timeout follows in SEND_RSP
    enable_i = 1'b1; tick();
    repeat (TC - 1) tick();
    send(ACTIVE_REQ);
    chk("tc_accept_tx", 32'(tx_valid), 32'(1));
    chk("tc_accept_err", 32'(err_o), 32'(0));
    tick();
    chk("tc_then_err", 32'(err_o), 32'(1));
    enable_i = 1'b0; tick();

    // Async reset mid-SEND_RSP
    enable_i = 1'b1; tick(); tick();
    send(ACTIVE_REQ);
    chk("ar_pre", 32'(tx_valid), 32'(1));
    #2 reset = 1'b1;
    #1;
    chk("ar_tx", 32'(tx_valid), 32'(0));
    chk("ar_msg", 32'(tx_msg), 32'(NOP));
    chk("ar_rst_cnt", 32'(rst_cnt), 32'(1));
    chk("ar_rx_req", 32'(rx_req), 32'(0));
    tick();
    reset = 1'b0;
    chk("ar_held", 32'(rx_req), 32'(0));
    tick();
    chk("ar_restart", 32'(rx_req), 32'(1));
    enable_i = 1'b0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
